turn_controller: RTL and testbench

- Game sequencer in front of the mark recorder.
- Accepts moves from two players (O = player 1, X = player 2), lets only the player whose turn it is move, and rejects moves to occupied or out-of-range cells.
- Issues exactly one single-cycle mark/position command per accepted move to the recorder.
- Reads back the recorder's grid to detect a win, then ends the game.

---
 rtl/turn_controller_pkg.sv | 35 +++
 rtl/turn_controller_line.sv | 22 ++
 rtl/turn_controller.sv | 183 ++++++++++++++++++
 tb/tb_turn_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_controller_pkg.sv
// Shared constants, state encoding and win-line table for the tic-tac-toe turn controller.
package turn_controller_pkg;

    localparam logic [1:0] MARK_EMPTY = 2'b00;
    localparam logic [1:0] MARK_O     = 2'b01;
    localparam logic [1:0] MARK_X     = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    localparam int NUM_CELLS = 9;
    localparam int GRID_W    = 2 * NUM_CELLS;
    localparam int NUM_LINES = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_O,
        WAIT_X,
        COMMIT,
        CHECK,
        DONE
    } state_t;

    // Rows, columns, then the two diagonals
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [1:0] cell_at(input logic [GRID_W-1:0] grid, input logic [3:0] pos);
        logic [GRID_W-1:0] shifted;
        shifted = grid >> {pos, 1'b0};
        return shifted[1:0];
    endfunction

endpackage

// File: rtl/turn_controller_line.sv
// Combinational check: does any of the eight win lines hold three copies of the given mark.
module line_detector
    import turn_controller_pkg::*;
(
    input  logic [GRID_W-1:0] grid,
    input  logic [1:0]        mark,
    output logic              hit
);

    always_comb begin
        hit = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (mark != MARK_EMPTY &&
                grid[2*WIN_LINES[l][0] +: 2] == mark &&
                grid[2*WIN_LINES[l][1] +: 2] == mark &&
                grid[2*WIN_LINES[l][2] +: 2] == mark) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Game sequencer in front of the mark recorder: turn arbitration, move legality, win/draw detection.
// Optional per-turn timeout is built only when TURN_TIMEOUT_EN is defined.
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int MAX_MOVES      = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              p1_valid,
    input  logic [3:0]        p1_pos,
    input  logic              p2_valid,
    input  logic [3:0]        p2_pos,
    input  logic [GRID_W-1:0] grid,
    output logic [1:0]        mark,
    output logic [3:0]        position,
    output logic              game_state,
    output logic              turn,
    output logic              illegal,
    output logic              timeout,
    output logic [1:0]        winner,
    output logic [7:0]        move_count
);

    if (MAX_MOVES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("turn_controller: MAX_MOVES must be >= 0 and TIMEOUT_CYCLES >= 1");
    end

    state_t     state, next_state;
    logic       in_wait;
    logic       mover_valid;
    logic [3:0] mover_pos;
    logic [1:0] mover_mark;
    logic       legal;
    logic       expired;
    logic       win_hit;
    logic       limit_hit;

    logic [1:0] mark_d;
    logic [3:0] position_d;
    logic       turn_d;
    logic       illegal_d;
    logic [1:0] winner_d;
    logic [7:0] move_count_d;
    logic       game_state_d;

    // Only the player whose turn it is gets looked at; the other strobe never matters
    assign in_wait     = (state == WAIT_O) || (state == WAIT_X);
    assign mover_valid = turn ? p2_valid : p1_valid;
    assign mover_pos   = turn ? p2_pos   : p1_pos;
    assign mover_mark  = turn ? MARK_X   : MARK_O;
    assign legal       = in_wait && mover_valid && (int'(mover_pos) < NUM_CELLS) &&
                         (cell_at(grid, mover_pos) == MARK_EMPTY);
    assign limit_hit   = (MAX_MOVES != 0) && (int'(move_count) == MAX_MOVES);

    line_detector u_line_detector (
        .grid (grid),
        .mark (mover_mark),
        .hit  (win_hit)
    );

`ifdef TURN_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        timeout_d;

    // Counts cycles spent in the current WAIT state; any entry into a WAIT restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if ((next_state == WAIT_O || next_state == WAIT_X) && next_state == state) begin
            wait_cnt <= wait_cnt + 32'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign expired   = in_wait && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign timeout_d = expired && !legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_d;
        end
    end
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mark       <= MARK_EMPTY;
            position   <= '0;
            game_state <= 1'b0;
            turn       <= 1'b0;
            illegal    <= 1'b0;
            winner     <= MARK_EMPTY;
            move_count <= '0;
        end else begin
            state      <= next_state;
            mark       <= mark_d;
            position   <= position_d;
            game_state <= game_state_d;
            turn       <= turn_d;
            illegal    <= illegal_d;
            winner     <= winner_d;
            move_count <= move_count_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:           if (start) next_state = WAIT_O;
            WAIT_O, WAIT_X: begin
                if (legal) begin
                    next_state = COMMIT;
                end else if (expired) begin
                    next_state = turn ? WAIT_O : WAIT_X;
                end
            end
            COMMIT:         next_state = CHECK;
            CHECK: begin
                if (win_hit || limit_hit) begin
                    next_state = DONE;
                end else begin
                    next_state = turn ? WAIT_O : WAIT_X;
                end
            end
            DONE:           next_state = DONE;
            default:        next_state = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so that the registered mark lines up with COMMIT
    always_comb begin
        mark_d       = MARK_EMPTY;
        position_d   = '0;
        turn_d       = turn;
        illegal_d    = 1'b0;
        winner_d     = winner;
        move_count_d = move_count;
        game_state_d = (next_state == WAIT_O) || (next_state == WAIT_X) ||
                       (next_state == COMMIT) || (next_state == CHECK);
        case (state)
            IDLE: begin
                if (start) begin
                    turn_d       = 1'b0;
                    winner_d     = MARK_EMPTY;
                    move_count_d = '0;
                end
            end
            WAIT_O, WAIT_X: begin
                if (legal) begin
                    mark_d     = mover_mark;
                    position_d = mover_pos;
                end else begin
                    illegal_d = mover_valid;
                    if (expired) turn_d = ~turn;
                end
            end
            COMMIT: begin
                move_count_d = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
            end
            CHECK: begin
                if (win_hit) begin
                    winner_d = mover_mark;
                end else if (limit_hit) begin
                    winner_d = WIN_DRAW;
                end else begin
                    turn_d = ~turn;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: stimulus queues expected recorder commands and pulses,
// a negedge monitor pops and compares them; a MAX_MOVES=4 copy checks the forced draw.
module tb_turn_controller;

    localparam logic [1:0] M_O    = 2'b01;
    localparam logic [1:0] M_X    = 2'b10;
    localparam logic [1:0] M_DRAW = 2'b11;

    typedef struct packed {
        logic [1:0] mark;
        logic [3:0] pos;
        logic       illegal;
        logic       timeout;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, p1_valid, p2_valid;
    logic [3:0]  p1_pos, p2_pos;
    logic [17:0] grid, lim_grid;

    logic [1:0]  mark, winner, lim_mark, lim_winner;
    logic [3:0]  position, lim_position;
    logic        game_state, turn, illegal, timeout;
    logic        lim_game_state, lim_turn, lim_illegal, lim_timeout;
    logic [7:0]  move_count, lim_move_count;

    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    turn_controller #(.MAX_MOVES(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_valid(p1_valid), .p1_pos(p1_pos), .p2_valid(p2_valid), .p2_pos(p2_pos),
        .grid(grid), .mark(mark), .position(position), .game_state(game_state),
        .turn(turn), .illegal(illegal), .timeout(timeout), .winner(winner),
        .move_count(move_count)
    );

    turn_controller #(.MAX_MOVES(4), .TIMEOUT_CYCLES(8)) dut_lim (
        .clk(clk), .rst(rst), .start(start),
        .p1_valid(p1_valid), .p1_pos(p1_pos), .p2_valid(p2_valid), .p2_pos(p2_pos),
        .grid(lim_grid), .mark(lim_mark), .position(lim_position), .game_state(lim_game_state),
        .turn(lim_turn), .illegal(lim_illegal), .timeout(lim_timeout), .winner(lim_winner),
        .move_count(lim_move_count)
    );

    // Recorder models: write the commanded mark into the grid, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid <= '0;
        end else if (mark != 2'b00 && position < 4'd9) begin
            grid[position*2 +: 2] <= mark;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lim_grid <= '0;
        end else if (lim_mark != 2'b00 && lim_position < 4'd9) begin
            lim_grid[lim_position*2 +: 2] <= lim_mark;
        end
    end

    // Monitor: every command or pulse the DUT presents must match the head of the queue
    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (rst && (mark != 2'b00 || illegal || timeout)) begin
            got.mark    = mark;
            got.pos     = position;
            got.illegal = illegal;
            got.timeout = timeout;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_event: got mark=%b pos=%0d illegal=%b timeout=%b, required no event",
                         got.mark, got.pos, got.illegal, got.timeout);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("[TB] FAIL event: got mark=%b pos=%0d illegal=%b timeout=%b, required mark=%b pos=%0d illegal=%b timeout=%b",
                             got.mark, got.pos, got.illegal, got.timeout,
                             want.mark, want.pos, want.illegal, want.timeout);
                end
            end
        end
    end

    function automatic ev_t cmd_ev(input logic [1:0] m, input logic [3:0] p);
        ev_t e;
        e.mark = m; e.pos = p; e.illegal = 1'b0; e.timeout = 1'b0;
        return e;
    endfunction

    function automatic ev_t pulse_ev(input logic ill, input logic tmo);
        ev_t e;
        e.mark = 2'b00; e.pos = 4'd0; e.illegal = ill; e.timeout = tmo;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_mark"},       32'(mark),       32'd0);
        check_output({tag, "_position"},   32'(position),   32'd0);
        check_output({tag, "_game_state"}, 32'(game_state), 32'd0);
        check_output({tag, "_turn"},       32'(turn),       32'd0);
        check_output({tag, "_illegal"},    32'(illegal),    32'd0);
        check_output({tag, "_timeout"},    32'(timeout),    32'd0);
        check_output({tag, "_winner"},     32'(winner),     32'd0);
        check_output({tag, "_move_count"}, 32'(move_count), 32'd0);
    endtask

    // Called at posedge+1; holds the strobes for one cycle and, for a legal move,
    // returns in the first cycle of the next WAIT state
    task automatic apply_stimulus(input logic v1, input logic [3:0] pos1,
                                  input logic v2, input logic [3:0] pos2, input ev_t expected);
        exp_q.push_back(expected);
        p1_valid = v1; p1_pos = pos1;
        p2_valid = v2; p2_pos = pos2;
        @(posedge clk); #1;
        p1_valid = 1'b0; p2_valid = 1'b0;
        if (expected.mark != 2'b00) begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_game();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] exp_mark;
        rst = 1'b1; start = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_pos = '0; p2_pos = '0;
        #2;
        do_reset();

        // Game 1: first move, both-strobe arbitration, out-of-range, then a legal X move
        start_game();
        apply_stimulus(1'b1, 4'd4, 1'b0, 4'd0, cmd_ev(M_O, 4'd4));
        check_output("o4_turn",       32'(turn),       32'd1);
        check_output("o4_move_count", 32'(move_count), 32'd1);
        check_output("o4_game_state", 32'(game_state), 32'd1);
        apply_stimulus(1'b1, 4'd0, 1'b1, 4'd4, pulse_ev(1'b1, 1'b0));
        check_output("both_strobe_turn",  32'(turn),       32'd1);
        check_output("both_strobe_count", 32'(move_count), 32'd1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 4'd9, pulse_ev(1'b1, 1'b0));
        check_output("pos9_turn", 32'(turn), 32'd1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 4'd0, cmd_ev(M_X, 4'd0));
        check_output("x0_turn",       32'(turn),       32'd0);
        check_output("x0_move_count", 32'(move_count), 32'd2);

        // Game 2: O completes the top row on move 5; the MAX_MOVES=4 copy draws at move 4
        do_reset();
        start_game();
        apply_stimulus(1'b1, 4'd0, 1'b0, 4'd0, cmd_ev(M_O, 4'd0));
        apply_stimulus(1'b0, 4'd0, 1'b1, 4'd3, cmd_ev(M_X, 4'd3));
        apply_stimulus(1'b1, 4'd1, 1'b0, 4'd0, cmd_ev(M_O, 4'd1));
        check_output("lim_winner_move3", 32'(lim_winner), 32'd0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 4'd4, cmd_ev(M_X, 4'd4));
        check_output("lim_draw_winner", 32'(lim_winner),     32'(M_DRAW));
        check_output("lim_draw_state",  32'(lim_game_state), 32'd0);
        check_output("lim_draw_count",  32'(lim_move_count), 32'd4);
        check_output("move4_winner",    32'(winner),         32'd0);
        check_output("move4_turn",      32'(turn),           32'd0);
        apply_stimulus(1'b1, 4'd2, 1'b0, 4'd0, cmd_ev(M_O, 4'd2));
        check_output("win_winner", 32'(winner),     32'(M_O));
        check_output("win_state",  32'(game_state), 32'd0);
        check_output("win_count",  32'(move_count), 32'd5);
        p1_valid = 1'b1; p1_pos = 4'd5; p2_valid = 1'b1; p2_pos = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        p1_valid = 1'b0; p2_valid = 1'b0; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_output("done_winner_held", 32'(winner),         32'(M_O));
        check_output("done_state",       32'(game_state),     32'd0);
        check_output("done_count",       32'(move_count),     32'd5);
        check_output("lim_done_winner",  32'(lim_winner),     32'(M_DRAW));

        // Game 3: O stays idle for the whole turn budget, then reset lands in COMMIT
        do_reset();
        start_game();
        repeat (7) @(posedge clk);
        #1;
        check_output("pre_expiry_timeout", 32'(timeout), 32'd0);
        check_output("pre_expiry_turn",    32'(turn),    32'd0);
`ifdef TURN_TIMEOUT_EN
        exp_q.push_back(pulse_ev(1'b0, 1'b1));
        @(posedge clk); #1;
        check_output("timeout_pulse", 32'(timeout),    32'd1);
        check_output("timeout_turn",  32'(turn),       32'd1);
        check_output("timeout_count", 32'(move_count), 32'd0);
        check_output("timeout_state", 32'(game_state), 32'd1);
        exp_mark = M_X;
        p2_valid = 1'b1; p2_pos = 4'd0;
`else
        @(posedge clk); #1;
        check_output("no_timeout_pulse", 32'(timeout), 32'd0);
        check_output("no_timeout_turn",  32'(turn),    32'd0);
        exp_mark = M_O;
        p1_valid = 1'b1; p1_pos = 4'd0;
`endif
        @(posedge clk); #1;
        check_output("commit_mark",     32'(mark),     32'(exp_mark));
        check_output("commit_position", 32'(position), 32'd0);
        rst = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0;
        #1;
        check_reset("reset_in_commit");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("after_reset_state", 32'(game_state), 32'd0);
        check_output("queue_empty",       32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
